// File: rtl/idexwb_pkg.sv
// -----------------------------------------------------------------------------
// idexwb_pkg
//   Shared definitions for the idexwb issue controller and its FIFO:
//   opcode encodings, the packed instruction layout and a small decode helper.
// -----------------------------------------------------------------------------
package idexwb_pkg;

   localparam logic [2:0] OPNOP  = 3'b000;
   localparam logic [2:0] OPADD  = 3'b001;
   localparam logic [2:0] OPMUL  = 3'b010;
   localparam logic [2:0] OPADDI = 3'b011;

   // {opcode, rs1, rs2, rd, imm} = 3+5+5+5+12 = 30 bits
   typedef struct packed {
      logic [2:0]  opcode;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [11:0] imm;
   } instr_t;

   // Only the register-register operations consume the second source.
   function automatic logic reads_rs2(input logic [2:0] opcode);
      return (opcode == OPADD) || (opcode == OPMUL);
   endfunction

endpackage

// File: rtl/idexwb_instr_fifo.sv
// -----------------------------------------------------------------------------
// idexwb_instr_fifo
//   Small synchronous FIFO of instr_t with first-word-fall-through head.
//   Ports:
//     clk_i    rising-edge clock
//     rst_i    synchronous reset, active-low (empties the FIFO)
//     push_i   write din_i (ignored when full)
//     pop_i    drop the head (ignored when empty)
//     din_i    instruction to write
//     dout_o   current head entry (valid when !empty_o)
//     full_o   DEPTH entries held
//     empty_o  no entries held
//     count_o  number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module idexwb_instr_fifo
   import idexwb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  instr_t                       din_i,
   output instr_t                       dout_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   instr_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/idexwb_issue_ctrl.sv
// -----------------------------------------------------------------------------
// idexwb_issue_ctrl
//   In-order issue controller for idexwb_pipe. Queues instructions, tracks
//   in-flight destination registers and inserts OPNOP bubbles on RAW hazards
//   because the pipe has no forwarding.
//   Ports:
//     clk_i, rst_i             clock, synchronous active-low reset
//     in_valid_i / in_ready_o  instruction handshake (push on valid && ready)
//     in_opcode_i .. in_imm_i  offered instruction fields
//     opcode_o, rs1_o, rs2_o,
//     rd_o, imm_o              registered instruction to the pipe
//     start_o                  registered pipe enable, 1 from first edge out of reset
//     busy_o                   FIFO non-empty or any register still pending
//     stall_cnt_o              saturating count of hazard bubbles
//     issue_cnt_o              saturating count of issued non-NOP instructions
// -----------------------------------------------------------------------------
module idexwb_issue_ctrl
   import idexwb_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PIPE_LAT = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2:0]       in_opcode_i,
   input  logic [4:0]       in_rs1_i,
   input  logic [4:0]       in_rs2_i,
   input  logic [4:0]       in_rd_i,
   input  logic [11:0]      in_imm_i,
   output logic [2:0]       opcode_o,
   output logic [4:0]       rs1_o,
   output logic [4:0]       rs2_o,
   output logic [4:0]       rd_o,
   output logic [11:0]      imm_o,
   output logic             start_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] issue_cnt_o
);

   localparam int PEND_W = $clog2(PIPE_LAT+1);
   localparam int FCNT_W = $clog2(DEPTH+1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // ---------------- FIFO ----------------
   instr_t              fifo_din, head;
   logic                fifo_push, fifo_pop;
   logic                fifo_full, fifo_empty;
   logic [FCNT_W-1:0]   fifo_count;

   assign fifo_din = '{opcode: in_opcode_i, rs1: in_rs1_i, rs2: in_rs2_i,
                       rd: in_rd_i, imm: in_imm_i};

   idexwb_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (fifo_din),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // ---------------- registered state ----------------
   logic              start_q;
   logic [2:0]        opcode_q, opcode_d;
   logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [11:0]       imm_q, imm_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
   logic [PEND_W-1:0] pend_q [32];
   logic [PEND_W-1:0] pend_d [32];

   // start_q doubles as "out of reset", keeping in_ready low during reset.
   assign in_ready_o = start_q && !fifo_full;
   assign fifo_push  = in_valid_i && in_ready_o;

   // A counter of 1 means the producer writes the RF on this very edge, so a
   // consumer issued now reads the new value: only values above 1 block.
   // This makes a dependent issue exactly PIPE_LAT edges after its producer.
   logic rs1_hz, rs2_hz, hazard;
   assign rs1_hz = (head.rs1 != '0) && (pend_q[head.rs1] > PEND_W'(1));
   assign rs2_hz = reads_rs2(head.opcode) && (head.rs2 != '0) &&
                   (pend_q[head.rs2] > PEND_W'(1));
   assign hazard = rs1_hz || rs2_hz;

   always_comb begin
      opcode_d    = OPNOP;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      imm_d       = '0;
      stall_cnt_d = stall_cnt_q;
      issue_cnt_d = issue_cnt_q;
      fifo_pop    = 1'b0;
      if (!fifo_empty) begin
         if (hazard) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
         end else begin
            fifo_pop = 1'b1;
            opcode_d = head.opcode;
            rs1_d    = head.rs1;
            rs2_d    = head.rs2;
            rd_d     = head.rd;
            imm_d    = head.imm;
            if (head.opcode != OPNOP) issue_cnt_d = sat_inc(issue_cnt_q);
         end
      end
   end

   // Scoreboard: decrement every edge, issue reloads (also covers WAW).
   always_comb begin
      for (int r = 0; r < 32; r++) begin
         pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - 1'b1 : pend_q[r];
      end
      if (fifo_pop && head.opcode != OPNOP && head.rd != '0)
         pend_d[head.rd] = PEND_W'(PIPE_LAT);
      pend_d[0] = '0;
   end

   logic any_pend;
   always_comb begin
      any_pend = 1'b0;
      for (int r = 1; r < 32; r++) any_pend = any_pend || (pend_q[r] != '0);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         start_q     <= 1'b0;
         opcode_q    <= OPNOP;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         stall_cnt_q <= '0;
         issue_cnt_q <= '0;
         for (int r = 0; r < 32; r++) pend_q[r] <= '0;
      end else begin
         start_q     <= 1'b1;
         opcode_q    <= opcode_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         imm_q       <= imm_d;
         stall_cnt_q <= stall_cnt_d;
         issue_cnt_q <= issue_cnt_d;
         for (int r = 0; r < 32; r++) pend_q[r] <= pend_d[r];
      end
   end

   assign opcode_o    = opcode_q;
   assign rs1_o       = rs1_q;
   assign rs2_o       = rs2_q;
   assign rd_o        = rd_q;
   assign imm_o       = imm_q;
   assign start_o     = start_q;
   assign busy_o      = (fifo_count != '0) || any_pend;
   assign stall_cnt_o = stall_cnt_q;
   assign issue_cnt_o = issue_cnt_q;

endmodule

// File: tb/tb_idexwb_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_idexwb_issue_ctrl
//   Directed bench for idexwb_issue_ctrl. Accepted instructions are queued as
//   expected issues; a monitor pops and compares every non-NOP issue.
// -----------------------------------------------------------------------------
module tb_idexwb_issue_ctrl;
   import idexwb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_opcode;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [11:0] in_imm;
   logic [2:0]  opcode;
   logic [4:0]  rs1, rs2, rd;
   logic [11:0] imm;
   logic        start, busy;
   logic [15:0] stall_cnt, issue_cnt;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   instr_t exp_q [$];
   int     hist  [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   idexwb_issue_ctrl #(.DEPTH(4), .PIPE_LAT(3), .CNT_W(16)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_opcode_i (in_opcode),
      .in_rs1_i    (in_rs1),
      .in_rs2_i    (in_rs2),
      .in_rd_i     (in_rd),
      .in_imm_i    (in_imm),
      .opcode_o    (opcode),
      .rs1_o       (rs1),
      .rs2_o       (rs2),
      .rd_o        (rd),
      .imm_o       (imm),
      .start_o     (start),
      .busy_o      (busy),
      .stall_cnt_o (stall_cnt),
      .issue_cnt_o (issue_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction until accepted; returns the number of refused edges.
   task automatic push(input logic [2:0] op, input int s1, input int s2,
                       input int d, input int im, output int rej);
      instr_t e;
      rej       = 0;
      in_valid  = 1'b1;
      in_opcode = op;
      in_rs1    = 5'(s1);
      in_rs2    = 5'(s2);
      in_rd     = 5'(d);
      in_imm    = 12'(im);
      e = '{opcode: op, rs1: 5'(s1), rs2: 5'(s2), rd: 5'(d), imm: 12'(im)};
      for (int k = 0; k < 40; k++) begin
         if (in_ready) begin
            if (op != OPNOP) exp_q.push_back(e);
            step();
            in_valid = 1'b0;
            return;
         end
         rej++;
         step();
      end
      check("push_timeout", 32'(rej), 32'd0);
      in_valid = 1'b0;
   endtask

   // Monitor: outputs are registered, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && opcode != OPNOP) begin
         hist.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("spurious_issue", {2'b0, opcode, rs1, rs2, rd, imm}, 32'd0);
         end else begin
            instr_t e;
            e = exp_q.pop_front();
            check("issue_fields", {2'b0, opcode, rs1, rs2, rd, imm}, {2'b0, e});
            $display("issue cyc=%0d op=%0d rs1=%0d rs2=%0d rd=%0d imm=%0d",
                     cyc, opcode, rs1, rs2, rd, $signed(imm));
         end
      end
   end

   initial begin
      int r, rej_tot;
      rst_n = 1'b0; in_valid = 1'b0; in_opcode = OPNOP;
      in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;

      // 1. reset
      step(); step();
      check("rst_opcode", 32'(opcode), 32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
      rst_n = 1'b1;
      step();
      check("post_rst_start", 32'(start), 32'd1);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // 2. independent stream
      hist.delete();
      push(OPADDI, 0, 0, 1, 5, r);
      push(OPADDI, 0, 0, 2, -3, r);
      push(OPADDI, 0, 0, 3, 7, r);
      push(OPADDI, 0, 0, 4, 100, r);
      repeat (6) step();
      check("indep_count", 32'(hist.size()), 32'd4);
      check("indep_span", 32'(hist[3] - hist[0]), 32'd3);
      check("indep_stall_cnt", 32'(stall_cnt), 32'd0);
      check("indep_issue_cnt", 32'(issue_cnt), 32'd4);
      check("indep_idle_busy", 32'(busy), 32'd0);

      // 3. RAW hazard
      hist.delete();
      push(OPADDI, 0, 0, 1, 10, r);
      push(OPADD, 1, 1, 2, 0, r);
      repeat (6) step();
      check("raw_count", 32'(hist.size()), 32'd2);
      check("raw_distance", 32'(hist[1] - hist[0]), 32'd3);
      check("raw_stall_cnt", 32'(stall_cnt), 32'd2);

      // 4. full FIFO behind a chain of dependent MULs
      hist.delete();
      rej_tot = 0;
      push(OPADDI, 0, 0, 9, 1, r);
      for (int i = 0; i < 6; i++) begin
         push(OPMUL, 9 + i, 9 + i, 10 + i, 0, r);
         rej_tot += r;
      end
      repeat (30) step();
      check("full_rejects", 32'(rej_tot), 32'd2);
      check("full_all_issued", 32'(exp_q.size()), 32'd0);
      check("full_issue_count", 32'(hist.size()), 32'd7);
      check("full_stall_cnt", 32'(stall_cnt), 32'd14);
      check("full_issue_cnt", 32'(issue_cnt), 32'd13);

      // 5. rs2 ignored for ADDI, rd=0 sets no pend
      hist.delete();
      push(OPADDI, 0, 0, 7, 1, r);
      push(OPADDI, 0, 7, 8, 1, r);
      push(OPADD, 3, 4, 0, 0, r);
      push(OPADD, 0, 0, 5, 0, r);
      repeat (8) step();
      check("rs2ign_count", 32'(hist.size()), 32'd4);
      check("rs2ign_distance", 32'(hist[1] - hist[0]), 32'd1);
      check("rd0_distance", 32'(hist[3] - hist[2]), 32'd1);
      check("rs2ign_stall_cnt", 32'(stall_cnt), 32'd14);
      check("rs2ign_issue_cnt", 32'(issue_cnt), 32'd17);

      // 6. reset while stalled with queued entries
      push(OPADDI, 0, 0, 1, 1, r);
      push(OPADD, 1, 1, 2, 0, r);
      push(OPADD, 1, 1, 3, 0, r);
      push(OPADD, 1, 1, 4, 0, r);
      check("midrst_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      step();
      check("midrst_start", 32'(start), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_opcode", 32'(opcode), 32'd0);
      check("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("midrst_issue_cnt", 32'(issue_cnt), 32'd0);
      check("midrst_in_ready_after", 32'(in_ready), 32'd1);
      push(OPADD, 2, 3, 5, 0, r);
      repeat (4) step();
      check("midrst_only_new", 32'(exp_q.size()), 32'd0);
      check("midrst_new_issue_cnt", 32'(issue_cnt), 32'd1);
      check("midrst_new_stall_cnt", 32'(stall_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
